// File: rtl/pattern_detector.sv
// rtl/pattern_detector.sv - serial bit-pattern detector with overlap control and saturating match counter
module pattern_detector #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_sig,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               pattern_found,
   output logic [CNT_W-1:0]   match_count
);

   localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

   logic [MAX_LEN-1:0] pat_r;
   logic [LEN_W-1:0]   len_r;
   logic               ovl_r;
   logic [MAX_LEN-1:0] window_r;
   logic [LEN_W-1:0]   fill_r;

   logic [MAX_LEN-1:0] win_nxt;
   logic [LEN_W-1:0]   fill_inc;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W-1:0]   cfg_len_clamped;
   logic               accept;
   logic               match;

   // Only the low len_r bits of the updated window take part in the compare.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len_r));
      end
   end

   assign win_nxt         = {window_r[MAX_LEN-2:0], in_sig};
   assign fill_inc        = (fill_r == MAX_LEN_W) ? fill_r : fill_r + LEN_W'(1);
   assign cfg_len_clamped = (cfg_len > MAX_LEN_W) ? MAX_LEN_W : cfg_len;
   assign accept          = in_valid & ~cfg_we;
   assign match           = accept && (len_r != '0) && (fill_inc >= len_r) &&
                            (((win_nxt ^ pat_r) & len_mask) == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_r    <= '0;
         len_r    <= '0;
         ovl_r    <= 1'b0;
         window_r <= '0;
         fill_r   <= '0;
      end else if (cfg_we) begin
         pat_r    <= cfg_pattern;
         len_r    <= cfg_len_clamped;
         ovl_r    <= cfg_overlap;
         window_r <= '0;
         fill_r   <= '0;
      end else if (in_valid) begin
         window_r <= win_nxt;
         // Non-overlapping mode restarts the fill so the next match needs len_r fresh bits.
         fill_r   <= (match && !ovl_r) ? '0 : fill_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern_found <= 1'b0;
         match_count   <= '0;
      end else begin
         pattern_found <= match;
         if (cnt_clr) begin
            match_count <= '0;
         end else if (match && (match_count != '1)) begin
            match_count <= match_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pattern_detector.sv
// tb/tb_pattern_detector.sv - self-checking bench for pattern_detector against a queue-based model
module tb_pattern_detector;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_sig = 1'b0;
   logic       cfg_we = 1'b0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic       cfg_overlap = 1'b0;
   logic       cnt_clr = 1'b0;
   logic       pattern_found, pattern_found2;
   logic [7:0] match_count;
   logic [1:0] match_count2;

   int total = 0;
   int bad = 0;
   int pulses = 0;
   bit started = 0;

   // model state
   bit   hist[$];
   int   m_len = 0;
   bit   m_ovl = 0;
   logic [7:0] m_pat = '0;
   int   fresh = 0;
   bit   m_found = 0;
   int   m_cnt8 = 0;
   int   m_cnt2 = 0;

   always #5 clk = ~clk;

   pattern_detector #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sig(in_sig), .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cnt_clr(cnt_clr), .pattern_found(pattern_found), .match_count(match_count)
   );

   pattern_detector #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sig(in_sig), .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cnt_clr(cnt_clr), .pattern_found(pattern_found2), .match_count(match_count2)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      m_len = 0; m_ovl = 0; m_pat = '0; fresh = 0; m_found = 0; m_cnt8 = 0; m_cnt2 = 0;
   endtask

   // Called at a falling edge; applies one cycle of inputs and returns at the next falling edge.
   task automatic cyc(input bit v, input bit b, input bit we, input bit clr);
      bit m;
      in_valid = v; in_sig = b; cfg_we = we; cnt_clr = clr;
      @(posedge clk);
      m = 0;
      if (rst) begin
         model_reset();
      end else if (we) begin
         m_pat = cfg_pattern;
         m_len = (cfg_len > 8) ? 8 : int'(cfg_len);
         m_ovl = cfg_overlap;
         hist.delete();
         fresh = 0;
      end else if (v) begin
         hist.push_back(b);
         fresh = (fresh + 1 > 8) ? 8 : fresh + 1;
         if (m_len != 0 && fresh >= m_len) begin
            m = 1;
            for (int k = 0; k < m_len; k++)
               if (hist[hist.size() - 1 - k] != m_pat[k]) m = 0;
         end
         if (m && !m_ovl) fresh = 0;
      end
      if (!rst) begin
         m_found = m;
         if (clr) begin
            m_cnt8 = 0; m_cnt2 = 0;
         end else if (m) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
         end
      end
      @(negedge clk);
      if (pattern_found) pulses++;
   endtask

   task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input bit o, input bit clr);
      cfg_pattern = p; cfg_len = l; cfg_overlap = o;
      cyc(0, 0, 1, clr);
      pulses = 0;
   endtask

   task automatic feed(input int n, input logic [31:0] bits);
      for (int i = n - 1; i >= 0; i--) cyc(1, bits[i], 0, 0);
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("found", int'(pattern_found), int'(m_found));
         chk("count", int'(match_count), m_cnt8);
         chk("found2", int'(pattern_found2), int'(m_found));
         chk("count2", int'(match_count2), m_cnt2);
      end
   end

   initial begin
      @(negedge clk);
      cyc(0, 0, 0, 0);
      started = 1;
      chk("rst_found", int'(pattern_found), 0);
      chk("rst_count", int'(match_count), 0);
      rst = 1'b0;

      // 110 overlapping over 110110
      load_cfg(8'b110, 3, 1, 1);
      feed(6, 32'b110110);
      chk("s1_pulses", pulses, 2);
      chk("s1_count", int'(match_count), 2);

      // 101 overlapping vs non-overlapping over 10101
      load_cfg(8'b101, 3, 1, 1);
      feed(5, 32'b10101);
      chk("s2o_pulses", pulses, 2);
      chk("s2o_count", int'(match_count), 2);
      load_cfg(8'b101, 3, 0, 1);
      feed(3, 32'b101);
      chk("s2n_first", int'(pattern_found), 1);
      feed(2, 32'b01);
      chk("s2n_pulses", pulses, 1);
      chk("s2n_count", int'(match_count), 1);

      // 110 with gaps
      load_cfg(8'b110, 3, 1, 1);
      cyc(1, 1, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      chk("gap_none", pulses, 0);
      cyc(1, 0, 0, 0);
      chk("gap_pulse", int'(pattern_found), 1);
      cyc(0, 0, 0, 0);
      chk("gap_pulses", pulses, 1);

      // cfg_len above MAX_LEN acts as 8
      load_cfg(8'hA5, 15, 0, 1);
      feed(7, 32'b1010010);
      chk("len8_early", pulses, 0);
      feed(1, 32'b1);
      chk("len8_pulse", int'(pattern_found), 1);
      chk("len8_count", int'(match_count), 1);

      // disabled with length 0
      load_cfg(8'h00, 0, 1, 0);
      for (int i = 0; i < 20; i++) cyc(1, 1'($urandom_range(0, 1)), 0, 0);
      chk("len0_pulses", pulses, 0);

      // saturation with CNT_W=2, then clear coinciding with a match
      load_cfg(8'b11, 2, 1, 1);
      feed(6, 32'b111111);
      chk("sat_pulses", pulses, 5);
      chk("sat_count8", int'(match_count), 5);
      chk("sat_count2", int'(match_count2), 3);
      cyc(1, 1, 0, 1);
      chk("clr_pulse", int'(pattern_found), 1);
      chk("clr_count8", int'(match_count), 0);
      chk("clr_count2", int'(match_count2), 0);

      // asynchronous reset mid-pattern
      load_cfg(8'b110, 3, 1, 0);
      feed(5, 32'b11011);
      chk("pre_rst_count", int'(match_count), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_found", int'(pattern_found), 0);
      chk("arst_count", int'(match_count), 0);
      model_reset();
      #2;
      cyc(0, 0, 0, 0);
      rst = 1'b0;
      feed(1, 32'b0);
      load_cfg(8'b110, 3, 1, 0);
      feed(1, 32'b0);
      cyc(0, 0, 0, 0);
      chk("post_rst_pulses", pulses, 0);

      started = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
